// File: rtl/dummy_slave_pkg.sv
// dummy_slave_pkg: shared constants, FSM state types and the burst
// legality rule used by both the write and read paths of dummy_slave.
// Build option: DUMMY_SLAVE_WRAP_EN enables WRAP bursts (len 1/3/7/15).
package dummy_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef DUMMY_SLAVE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  // Burst shape latched at the address handshake.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } burst_t;

  // A burst touches memory only if its size fits the 32-bit bus and its
  // type is one we implement; anything else is answered with SLVERR.
  function automatic logic burst_ok(input logic [7:0] len, input logic [2:0] size,
                                    input logic [1:0] burst);
    logic ok;
    ok = 1'b0;
    if (size <= 3'd2) begin
      case (burst)
        BURST_FIXED, BURST_INCR: ok = 1'b1;
        BURST_WRAP: ok = WRAP_EN && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        default:    ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/dummy_slave_if.sv
// dummy_slave_if: AXI4 slave bus bundle (AW, W, B, AR, R channels).
// master modport drives requests/ready-for-responses, slave modport the rest.
interface dummy_slave_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int ID_WIDTH   = 1
);
  logic [ID_WIDTH-1:0]   AWID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWVALID, AWREADY;

  logic [31:0]           WDATA;
  logic [3:0]            WSTRB;
  logic                  WLAST, WVALID, WREADY;

  logic [ID_WIDTH-1:0]   BID;
  logic [1:0]            BRESP;
  logic                  BVALID, BREADY;

  logic [ID_WIDTH-1:0]   ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID, ARREADY;

  logic [ID_WIDTH-1:0]   RID;
  logic [31:0]           RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST, RVALID, RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/dummy_slave_addr_gen.sv
// dummy_slave_addr_gen: combinational next-beat address for an AXI burst.
// Ports: addr_i current byte address, len_i/size_i/burst_i burst shape,
//        next_addr_o address of the following beat.
import dummy_slave_pkg::*;

module dummy_slave_addr_gen #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);
  logic [ADDR_WIDTH-1:0] step, win, mask, sum;

  always_comb begin
    step = ADDR_WIDTH'(1) << size_i;
    // Wrap window is (len+1) beats wide; legal wrap lengths make it a
    // power of two, so the in-window offset is just a mask.
    win  = (ADDR_WIDTH'({1'b0, len_i}) + ADDR_WIDTH'(1)) << size_i;
    mask = win - ADDR_WIDTH'(1);
    sum  = addr_i + step;
    case (burst_i)
      BURST_INCR: next_addr_o = sum;
      BURST_WRAP: next_addr_o = (addr_i & ~mask) | (sum & mask);
      default:    next_addr_o = addr_i;
    endcase
  end
endmodule

// File: rtl/dummy_slave.sv
// dummy_slave: AXI4 memory slave backed by 2^(ADDR_WIDTH-2) 32-bit words.
// Ports: ACLK, ARESET (async, active high), s_axi (dummy_slave_if.slave).
// Independent write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_DATA) FSMs;
// illegal bursts complete with SLVERR and never touch memory.
// Build option: DUMMY_SLAVE_WRAP_EN (see dummy_slave_pkg).
import dummy_slave_pkg::*;

module dummy_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int ID_WIDTH   = 1
) (
  input logic           ACLK,
  input logic           ARESET,
  dummy_slave_if.slave  s_axi
);
  localparam int WW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** WW;

  logic [31:0] mem_q [DEPTH];

  // ---------------- write path ----------------
  wstate_e               w_state_q;
  logic                  awready_q, wready_q, bvalid_q, wok_q;
  logic [1:0]            bresp_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  burst_t                wctx_q;
  logic [7:0]            wcnt_q;
  logic                  w_beat, w_final, w_end, wlast_bad;

  assign w_beat    = (w_state_q == W_DATA) && s_axi.WVALID;
  assign w_final   = (wcnt_q == wctx_q.len);
  assign w_end     = s_axi.WLAST || w_final;
  assign wlast_bad = s_axi.WLAST != w_final;

  dummy_slave_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr (
    .addr_i(waddr_q), .len_i(wctx_q.len), .size_i(wctx_q.size),
    .burst_i(wctx_q.burst), .next_addr_o(waddr_d)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      waddr_q   <= '0;
      wctx_q    <= '0;
      wcnt_q    <= '0;
      wok_q     <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awready_q && s_axi.AWVALID) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= W_DATA;
            bid_q     <= s_axi.AWID;
            waddr_q   <= s_axi.AWADDR;
            wctx_q    <= '{len: s_axi.AWLEN, size: s_axi.AWSIZE, burst: s_axi.AWBURST};
            wcnt_q    <= '0;
            wok_q     <= burst_ok(s_axi.AWLEN, s_axi.AWSIZE, s_axi.AWBURST);
          end
        end
        W_DATA: begin
          if (s_axi.WVALID) begin
            waddr_q <= waddr_d;
            wcnt_q  <= wcnt_q + 8'd1;
            // First of WLAST or beat len+1 closes the burst; any mismatch
            // between the two is reported rather than waited out.
            if (w_end) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= (!wok_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Memory is never reset so contents survive ARESET.
  always_ff @(posedge ACLK) begin
    if (w_beat && wok_q) begin
      for (int b = 0; b < 4; b++)
        if (s_axi.WSTRB[b]) mem_q[waddr_q[ADDR_WIDTH-1:2]][8*b +: 8] <= s_axi.WDATA[8*b +: 8];
    end
  end

  assign s_axi.AWREADY = awready_q;
  assign s_axi.WREADY  = wready_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.BID     = bid_q;

  // ---------------- read path ----------------
  rstate_e               r_state_q;
  logic                  arready_q, rvalid_q, rlast_q, rok_q, ar_ok;
  logic [31:0]           rdata_q;
  logic [1:0]            rresp_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, rgen_addr;
  burst_t                rctx_q, ar_ctx, rgen_ctx;
  logic [7:0]            rcnt_q;

  assign ar_ctx = '{len: s_axi.ARLEN, size: s_axi.ARSIZE, burst: s_axi.ARBURST};
  assign ar_ok  = burst_ok(s_axi.ARLEN, s_axi.ARSIZE, s_axi.ARBURST);

  // While idle the generator looks at the incoming AR request, so the
  // address of beat 2 is ready at the same edge that loads beat 1.
  assign rgen_addr = (r_state_q == R_IDLE) ? s_axi.ARADDR : raddr_q;
  assign rgen_ctx  = (r_state_q == R_IDLE) ? ar_ctx : rctx_q;

  dummy_slave_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr (
    .addr_i(rgen_addr), .len_i(rgen_ctx.len), .size_i(rgen_ctx.size),
    .burst_i(rgen_ctx.burst), .next_addr_o(raddr_d)
  );

  // Reads sample mem_q at the clock edge, so a same-cycle write to the same
  // word is not yet visible: the read returns the old contents.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      raddr_q   <= '0;
      rctx_q    <= '0;
      rcnt_q    <= '0;
      rok_q     <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arready_q && s_axi.ARVALID) begin
            arready_q <= 1'b0;
            r_state_q <= R_DATA;
            rid_q     <= s_axi.ARID;
            rctx_q    <= ar_ctx;
            rok_q     <= ar_ok;
            raddr_q   <= raddr_d;
            rcnt_q    <= '0;
            rvalid_q  <= 1'b1;
            rlast_q   <= (s_axi.ARLEN == 8'd0);
            rresp_q   <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_q   <= ar_ok ? mem_q[s_axi.ARADDR[ADDR_WIDTH-1:2]] : 32'h0;
          end
        end
        R_DATA: begin
          if (s_axi.RREADY) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              rcnt_q  <= rcnt_q + 8'd1;
              rlast_q <= ((rcnt_q + 8'd1) == rctx_q.len);
              raddr_q <= raddr_d;
              rdata_q <= rok_q ? mem_q[raddr_q[ADDR_WIDTH-1:2]] : 32'h0;
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi.ARREADY = arready_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RLAST   = rlast_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = rresp_q;
  assign s_axi.RID     = rid_q;

endmodule

// File: tb/tb_dummy_slave.sv
// tb_dummy_slave: randomized and directed bench for dummy_slave against a
// word-array memory model with burst addresses computed arithmetically.
module tb_dummy_slave;
  localparam int AW = 12, IW = 4, NW = 1024;

  logic ACLK = 1'b0, ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  dummy_slave_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) axi();
  dummy_slave #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (.ACLK(ACLK), .ARESET(ARESET), .s_axi(axi));

  int n_chk = 0, n_fail = 0;
  logic [31:0] model [NW];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd_beats [16];
  int          rd_n;
  logic [1:0]  last_bresp;
  logic [IW-1:0] last_bid;

  // byte address of beat 'beat' of a burst, modulo the 4 KiB space
  function automatic int beat_addr(int start, int beat, int len, int size, int burst);
    int nb, total, base;
    nb = 1 << size;
    if (burst == 0) return start;
    if (burst == 1) return (start + beat * nb) % 4096;
    total = (len + 1) * nb;
    base  = start - (start % total);
    return base + ((start - base + beat * nb) % total);
  endfunction

  function automatic bit model_ok(int len, int size, int burst);
    if (size > 2) return 1'b0;
    if (burst == 0 || burst == 1) return 1'b1;
`ifdef DUMMY_SLAVE_WRAP_EN
    if (burst == 2) return (len == 1 || len == 3 || len == 7 || len == 15);
`endif
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = '0; axi.AWBURST = '0; axi.AWVALID = 1'b0;
    axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0; axi.WVALID = 1'b0; axi.BREADY = 1'b0;
    axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = '0; axi.ARBURST = '0; axi.ARVALID = 1'b0;
    axi.RREADY = 1'b0;
  endtask

  // last_at: beat index carrying WLAST (> len means WLAST never asserted)
  task automatic write_burst(input logic [IW-1:0] id, input int addr, input int len, input int size,
                             input int burst, input int last_at, input int bdelay);
    int nbeats, cyc, w;
    bit hs, ok;
    logic [1:0] exp_resp;
    ok = model_ok(len, size, burst);
    nbeats = ((last_at < len) ? last_at : len) + 1;
    exp_resp = (ok && last_at == len) ? 2'b00 : 2'b10;
    axi.AWID = id; axi.AWADDR = AW'(addr); axi.AWLEN = 8'(len); axi.AWSIZE = 3'(size);
    axi.AWBURST = 2'(burst); axi.AWVALID = 1'b1;
    hs = 0; cyc = 0;
    while (!hs && cyc < 100) begin hs = axi.AWREADY; @(posedge ACLK); #1; cyc++; end
    axi.AWVALID = 1'b0;
    n_chk++;
    if (!hs) begin n_fail++; $display("FAIL aw_timeout: no AWREADY in %0d cycles", cyc); return; end
    n_chk++;
    if ({axi.AWREADY, axi.WREADY} !== 2'b01) begin
      n_fail++; $display("FAIL w_phase_ready: AWREADY,WREADY=%b required 01", {axi.AWREADY, axi.WREADY});
    end
    for (int b = 0; b < nbeats; b++) begin
      axi.WDATA = wd[b]; axi.WSTRB = ws[b]; axi.WLAST = (b == last_at); axi.WVALID = 1'b1;
      hs = 0; cyc = 0;
      while (!hs && cyc < 100) begin hs = axi.WREADY; @(posedge ACLK); #1; cyc++; end
      if (!hs) begin
        n_chk++; n_fail++; $display("FAIL w_timeout: beat %0d not accepted", b);
        axi.WVALID = 1'b0; return;
      end
      if (ok) begin
        w = beat_addr(addr, b, len, size, burst) / 4;
        for (int k = 0; k < 4; k++) if (ws[b][k]) model[w][8*k +: 8] = wd[b][8*k +: 8];
      end
    end
    axi.WVALID = 1'b0; axi.WLAST = 1'b0;
    cyc = 0;
    while (!axi.BVALID && cyc < 100) begin @(posedge ACLK); #1; cyc++; end
    repeat (bdelay) begin @(posedge ACLK); #1; end
    n_chk++;
    if (axi.BVALID !== 1'b1) begin n_fail++; $display("FAIL bvalid_hold: BVALID=%b required 1", axi.BVALID); return; end
    last_bresp = axi.BRESP; last_bid = axi.BID;
    axi.BREADY = 1'b1; @(posedge ACLK); #1; axi.BREADY = 1'b0;
    n_chk++;
    if (last_bresp !== exp_resp) begin n_fail++; $display("FAIL bresp: got %b required %b", last_bresp, exp_resp); end
    n_chk++;
    if (last_bid !== id) begin n_fail++; $display("FAIL bid: got %h required %h", last_bid, id); end
    n_chk++;
    if ({axi.BVALID, axi.AWREADY} !== 2'b01) begin
      n_fail++; $display("FAIL b_done: BVALID,AWREADY=%b required 01", {axi.BVALID, axi.AWREADY});
    end
  endtask

  // mode 0: RREADY held high, 1: toggles 1/0, 2: random
  task automatic read_burst(input logic [IW-1:0] id, input int addr, input int len, input int size,
                            input int burst, input int mode);
    int cyc, beat;
    bit hs, ok, stalled;
    logic [31:0] exp, held;
    logic held_last;
    ok = model_ok(len, size, burst);
    axi.ARID = id; axi.ARADDR = AW'(addr); axi.ARLEN = 8'(len); axi.ARSIZE = 3'(size);
    axi.ARBURST = 2'(burst); axi.ARVALID = 1'b1;
    hs = 0; cyc = 0;
    while (!hs && cyc < 100) begin hs = axi.ARREADY; @(posedge ACLK); #1; cyc++; end
    axi.ARVALID = 1'b0;
    n_chk++;
    if (!hs) begin n_fail++; $display("FAIL ar_timeout: no ARREADY in %0d cycles", cyc); return; end
    n_chk++;
    if ({axi.RVALID, axi.ARREADY} !== 2'b10) begin
      n_fail++; $display("FAIL r_first: RVALID,ARREADY=%b required 10", {axi.RVALID, axi.ARREADY});
    end
    beat = 0; cyc = 0; rd_n = 0;
    while (beat <= len && cyc < 1000) begin
      case (mode)
        0: axi.RREADY = 1'b1;
        1: axi.RREADY = (cyc % 2 == 0);
        default: axi.RREADY = 1'($urandom_range(0, 1));
      endcase
      stalled = 0;
      if (axi.RVALID !== 1'b1) begin
        n_chk++; n_fail++; $display("FAIL rvalid_drop: beat %0d RVALID=%b", beat, axi.RVALID);
      end else if (axi.RREADY) begin
        exp = ok ? model[beat_addr(addr, beat, len, size, burst) / 4] : 32'h0;
        n_chk++;
        if (axi.RDATA !== exp) begin n_fail++; $display("FAIL rdata: beat %0d got %h required %h", beat, axi.RDATA, exp); end
        n_chk++;
        if ({axi.RRESP, axi.RLAST, axi.RID} !== {(ok ? 2'b00 : 2'b10), (beat == len), id}) begin
          n_fail++; $display("FAIL rctl: beat %0d RRESP,RLAST,RID=%b/%b/%h required %b/%b/%h", beat,
                             axi.RRESP, axi.RLAST, axi.RID, (ok ? 2'b00 : 2'b10), (beat == len), id);
        end
        if (beat < 16) rd_beats[beat] = axi.RDATA;
        beat++; rd_n = beat;
      end else begin
        stalled = 1; held = axi.RDATA; held_last = axi.RLAST;
      end
      @(posedge ACLK); #1; cyc++;
      if (stalled) begin
        n_chk++;
        if ({axi.RVALID, axi.RDATA, axi.RLAST} !== {1'b1, held, held_last}) begin
          n_fail++; $display("FAIL r_stall: RDATA %h RLAST %b required %h %b", axi.RDATA, axi.RLAST, held, held_last);
        end
      end
    end
    axi.RREADY = 1'b0;
    n_chk++;
    if (beat != len + 1) begin n_fail++; $display("FAIL r_timeout: got %0d beats required %0d", beat, len + 1); end
    n_chk++;
    if ({axi.RVALID, axi.ARREADY} !== 2'b01) begin
      n_fail++; $display("FAIL r_done: RVALID,ARREADY=%b required 01", {axi.RVALID, axi.ARREADY});
    end
    if (mode == 0) begin
      n_chk++;
      if (cyc != len + 1) begin n_fail++; $display("FAIL r_throughput: %0d cycles required %0d", cyc, len + 1); end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    ARESET = 1'b1;
    #1;
    n_chk++;
    if ({axi.AWREADY, axi.WREADY, axi.BVALID, axi.BRESP, axi.BID, axi.ARREADY, axi.RVALID,
         axi.RDATA, axi.RRESP, axi.RLAST, axi.RID} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero (AWREADY %b ARREADY %b RVALID %b BVALID %b)",
                         axi.AWREADY, axi.ARREADY, axi.RVALID, axi.BVALID);
    end
    repeat (2) @(posedge ACLK);
    #1; ARESET = 1'b0; #1;
    n_chk++;
    if ({axi.AWREADY, axi.ARREADY} !== 2'b00) begin
      n_fail++; $display("FAIL reset_release: AWREADY,ARREADY=%b required 00", {axi.AWREADY, axi.ARREADY});
    end
    @(posedge ACLK); #1;
    n_chk++;
    if ({axi.AWREADY, axi.ARREADY} !== 2'b11) begin
      n_fail++; $display("FAIL ready_after_reset: AWREADY,ARREADY=%b required 11", {axi.AWREADY, axi.ARREADY});
    end
  endtask

  task automatic test_init();
    for (int b = 0; b < 16; b++) begin wd[b] = 32'h0; ws[b] = 4'hF; end
    for (int i = 0; i < NW; i++) model[i] = 32'h0;
    for (int a = 0; a < 4096; a += 64) write_burst(4'h0, a, 15, 2, 1, 15, 0);
  endtask

  task automatic test_incr();
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    for (int b = 0; b < 4; b++) ws[b] = 4'hF;
    write_burst(4'h3, 32'h010, 3, 2, 1, 3, 2);
    n_chk++;
    if (last_bresp !== 2'b00) begin n_fail++; $display("FAIL incr_bresp: got %b required 00", last_bresp); end
    read_burst(4'h5, 32'h010, 3, 2, 1, 0);
    n_chk++;
    if ({rd_beats[0], rd_beats[1], rd_beats[2], rd_beats[3]} !== {32'h11, 32'h22, 32'h33, 32'h44}) begin
      n_fail++; $display("FAIL incr_readback: got %h %h %h %h required 11 22 33 44",
                         rd_beats[0], rd_beats[1], rd_beats[2], rd_beats[3]);
    end
  endtask

  task automatic test_strobe();
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    write_burst(4'h1, 32'h020, 0, 2, 1, 0, 0);
    read_burst(4'h2, 32'h020, 0, 2, 1, 0);
    n_chk++;
    if (rd_beats[0] !== 32'h00BB00DD) begin n_fail++; $display("FAIL strobe: got %h required 00bb00dd", rd_beats[0]); end
  endtask

  task automatic test_wrap();
    logic [127:0] exp;
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    for (int b = 0; b < 4; b++) ws[b] = 4'hF;
    write_burst(4'h0, 32'h030, 3, 2, 1, 3, 0);
    wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3; wd[3] = 32'h4;
    write_burst(4'h7, 32'h038, 3, 2, 2, 3, 1);
`ifdef DUMMY_SLAVE_WRAP_EN
    exp = {32'h3, 32'h4, 32'h1, 32'h2};
    n_chk++;
    if (last_bresp !== 2'b00) begin n_fail++; $display("FAIL wrap_bresp: got %b required 00", last_bresp); end
`else
    exp = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
    n_chk++;
    if (last_bresp !== 2'b10) begin n_fail++; $display("FAIL wrap_bresp: got %b required 10", last_bresp); end
`endif
    read_burst(4'h4, 32'h030, 3, 2, 1, 0);
    n_chk++;
    if ({rd_beats[0], rd_beats[1], rd_beats[2], rd_beats[3]} !== exp) begin
      n_fail++; $display("FAIL wrap_mem: got %h %h %h %h required %h",
                         rd_beats[0], rd_beats[1], rd_beats[2], rd_beats[3], exp);
    end
    read_burst(4'h6, 32'h038, 3, 2, 2, 2);
  endtask

  task automatic test_early_last();
    for (int b = 0; b < 4; b++) begin wd[b] = 32'hC0DE0000 + b; ws[b] = 4'hF; end
    write_burst(4'hA, 32'h080, 3, 2, 1, 1, 0);
    n_chk++;
    if ({last_bresp, last_bid} !== {2'b10, 4'hA}) begin
      n_fail++; $display("FAIL early_last: BRESP %b BID %h required 10 a", last_bresp, last_bid);
    end
  endtask

  task automatic test_read_stall();
    for (int b = 0; b < 8; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    write_burst(4'h2, 32'h100, 7, 2, 1, 7, 0);
    read_burst(4'h9, 32'h100, 7, 2, 1, 1);
    n_chk++;
    if (rd_n != 8) begin n_fail++; $display("FAIL stall_beats: got %0d required 8", rd_n); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit hs;
    axi.ARID = 4'h3; axi.ARADDR = AW'(32'h100); axi.ARLEN = 8'd7; axi.ARSIZE = 3'd2;
    axi.ARBURST = 2'd1; axi.ARVALID = 1'b1;
    hs = 0; cyc = 0;
    while (!hs && cyc < 100) begin hs = axi.ARREADY; @(posedge ACLK); #1; cyc++; end
    axi.ARVALID = 1'b0; axi.RREADY = 1'b1;
    @(posedge ACLK); #1;          // beat 1 accepted, beat 2 on the bus
    ARESET = 1'b1; #1;
    n_chk++;
    if ({axi.RVALID, axi.RLAST, axi.RDATA, axi.ARREADY, axi.AWREADY} !== '0) begin
      n_fail++; $display("FAIL mid_reset: RVALID %b RLAST %b RDATA %h ARREADY %b required all 0",
                         axi.RVALID, axi.RLAST, axi.RDATA, axi.ARREADY);
    end
    axi.RREADY = 1'b0;
    @(posedge ACLK); #1;
    ARESET = 1'b0; #1;
    n_chk++;
    if (axi.ARREADY !== 1'b0) begin n_fail++; $display("FAIL mid_release: ARREADY %b required 0", axi.ARREADY); end
    @(posedge ACLK); #1;
    n_chk++;
    if ({axi.ARREADY, axi.AWREADY, axi.RVALID} !== 3'b110) begin
      n_fail++; $display("FAIL mid_ready: ARREADY,AWREADY,RVALID=%b required 110", {axi.ARREADY, axi.AWREADY, axi.RVALID});
    end
    read_burst(4'hE, 32'h100, 7, 2, 1, 0);
  endtask

  // W beat and R beat hit the same word on the same edge
  task automatic test_concurrent();
    int cyc;
    wd[0] = 32'h5555AAAA; ws[0] = 4'hF;
    write_burst(4'h0, 32'h200, 0, 2, 1, 0, 0);
    axi.AWID = 4'h1; axi.AWADDR = AW'(32'h200); axi.AWLEN = 8'd0; axi.AWSIZE = 3'd2; axi.AWBURST = 2'd1;
    axi.AWVALID = 1'b1;
    axi.WDATA = 32'h12345678; axi.WSTRB = 4'hF; axi.WLAST = 1'b1; axi.WVALID = 1'b1;
    @(posedge ACLK); #1;          // AW accepted
    axi.AWVALID = 1'b0;
    axi.ARID = 4'h8; axi.ARADDR = AW'(32'h200); axi.ARLEN = 8'd0; axi.ARSIZE = 3'd2; axi.ARBURST = 2'd1;
    axi.ARVALID = 1'b1;
    n_chk++;
    if ({axi.WREADY, axi.ARREADY} !== 2'b11) begin
      n_fail++; $display("FAIL conc_ready: WREADY,ARREADY=%b required 11", {axi.WREADY, axi.ARREADY});
    end
    @(posedge ACLK); #1;          // W beat and AR accepted together
    axi.WVALID = 1'b0; axi.WLAST = 1'b0; axi.ARVALID = 1'b0;
    n_chk++;
    if ({axi.RVALID, axi.RDATA} !== {1'b1, 32'h5555AAAA}) begin
      n_fail++; $display("FAIL conc_old_data: RVALID %b RDATA %h required 1 5555aaaa", axi.RVALID, axi.RDATA);
    end
    axi.RREADY = 1'b1; axi.BREADY = 1'b1;
    cyc = 0;
    while (axi.BVALID && cyc < 10) begin @(posedge ACLK); #1; cyc++; end
    axi.RREADY = 1'b0; axi.BREADY = 1'b0;
    @(posedge ACLK); #1;
    model[128] = 32'h12345678;
    read_burst(4'h8, 32'h200, 0, 2, 1, 0);
  endtask

  task automatic test_random();
    int size, burst, len, addr, last_at;
    int lens [5] = '{1, 3, 7, 15, 2};
    for (int it = 0; it < 30; it++) begin
      size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      burst = $urandom_range(0, 3);
      len   = (burst == 2) ? lens[$urandom_range(0, 4)] : $urandom_range(0, 15);
      addr  = $urandom_range(0, 4095) & ~((1 << size) - 1);
      for (int b = 0; b < 16; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
      last_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 16) : len;
      write_burst(IW'($urandom), addr, len, size, burst, last_at, $urandom_range(0, 2));
      if ($urandom_range(0, 1)) addr = $urandom_range(0, 4095) & ~((1 << size) - 1);
      read_burst(IW'($urandom), addr, len, size, burst, 2);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_incr();
    test_strobe();
    test_wrap();
    test_early_last();
    test_read_stall();
    test_reset_mid();
    test_concurrent();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/dummy_slave.md
DUMMY_SLAVE -- requirements
Module: dummy_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, byte-address width; memory holds 2^(ADDR_WIDTH-2) 32-bit words.
REQ-002 Parameter ID_WIDTH, default 1, width of all AXI ID fields.
REQ-003 ACLK  in  1  single clock; all logic on rising edge.
REQ-004 ARESET  in  1  asynchronous, active-high reset.
REQ-005 S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address channel.
REQ-006 S_AXI_AWVALID in 1, S_AXI_AWREADY out 1  write address handshake.
REQ-007 S_AXI_WDATA/WSTRB/WLAST/WVALID  in  32/4/1/1, S_AXI_WREADY out 1  write data channel.
REQ-008 S_AXI_BID/BRESP/BVALID  out  ID_WIDTH/2/1, S_AXI_BREADY in 1  write response channel.
REQ-009 S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1, S_AXI_ARREADY out 1  read address channel.
REQ-010 S_AXI_RID/RDATA/RRESP/RLAST/RVALID  out  ID_WIDTH/32/2/1/1, S_AXI_RREADY in 1  read data channel.

Function
REQ-011 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; read FSM SHALL have states R_IDLE, R_DATA; the two run independently.
REQ-012 AWREADY SHALL be high only in W_IDLE; an AW handshake latches ID/addr/len/size/burst and moves to W_DATA next cycle.
REQ-013 WREADY SHALL be high only in W_DATA; each W handshake writes bytes enabled by WSTRB to word addr[ADDR_WIDTH-1:2] and advances the address.
REQ-014 Address advance: FIXED holds address; INCR adds 2^size; WRAP adds 2^size and wraps within an aligned (len+1)*2^size window.
REQ-015 Addresses beyond memory size SHALL alias modulo memory size (upper bits ignored); no error.
REQ-016 Write burst ends on the beat with WLAST=1 or on beat AWLEN+1, whichever comes first; FSM moves to W_RESP next cycle.
REQ-017 BRESP SHALL be SLVERR (2'b10) if WLAST position differs from beat AWLEN+1, AWSIZE>2, or burst type unsupported; otherwise OKAY; BID = latched AWID.
REQ-018 Unsupported/oversize bursts SHALL still accept all W beats but SHALL NOT modify memory.
REQ-019 BVALID SHALL hold until BREADY; B handshake returns to W_IDLE next cycle.
REQ-020 ARREADY SHALL be high only in R_IDLE; first RVALID SHALL assert the cycle after the AR handshake.
REQ-021 R beats SHALL sustain one per cycle while RREADY=1; RDATA/RRESP/RLAST SHALL stay stable while RVALID=1 and RREADY=0.
REQ-022 RLAST SHALL be high on beat ARLEN+1 only; handshake of that beat returns to R_IDLE next cycle.
REQ-023 Read errors (ARSIZE>2, unsupported burst) SHALL return ARLEN+1 beats with RRESP=SLVERR and RDATA=0; RID = latched ARID on every beat.
REQ-024 Simultaneous R beat and W beat to same word: read SHALL return pre-write data.

Reset
REQ-025 ARESET SHALL force both FSMs idle and all outputs (AWREADY, WREADY, BVALID, BRESP, BID, ARREADY, RVALID, RDATA, RRESP, RLAST, RID) to 0 immediately.
REQ-026 AWREADY and ARREADY SHALL first assert the cycle after ARESET deasserts.
REQ-027 Reset mid-burst SHALL abandon the burst without response; memory contents are not cleared.

Configuration
REQ-028 Macro DUMMY_SLAVE_WRAP_EN defined: WRAP bursts with len in {1,3,7,15} supported per REQ-014; other WRAP lengths are errors.
REQ-029 Macro DUMMY_SLAVE_WRAP_EN undefined: every WRAP burst treated as unsupported (REQ-017/018/023); burst type 2'b11 always unsupported.

Structure
REQ-030 Package dummy_slave_pkg SHALL hold burst-type constants, RESP codes (OKAY, SLVERR), and write/read FSM state enums.
REQ-031 Sub-module dummy_slave_addr_gen SHALL compute next address from addr/len/size/burst; instantiated once per FSM.

Verification
REQ-032 Write INCR len=3 size=2 addr 0x010 data 0x11..0x44, WSTRB=4'hF -> BRESP OKAY; read back same burst -> 0x11,0x22,0x33,0x44, RLAST on beat 4.
REQ-033 Write 0xAABBCCDD WSTRB=4'b0101 over 0x00000000 at 0x020 -> read returns 0x00BB00DD.
REQ-034 WRAP len=3 at 0x038 (macro on) -> beats hit 0x038,0x03C,0x030,0x034; macro off -> BRESP SLVERR, memory unchanged.
REQ-035 Write len=3 with WLAST on beat 2 -> BRESP SLVERR, BID equals AWID.
REQ-036 Read len=7 with RREADY toggling 1/0 each cycle -> 8 beats, data stable during stalls, RLAST only on beat 8.
REQ-037 ARESET asserted during beat 2 of len=7 read -> RVALID low immediately, ARREADY high first cycle after release, next read correct.
